// File: rtl/poly_eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : poly_eval_pkg
//  Purpose  : Shared types and helpers for the Horner polynomial evaluator.
//  Revision : 1.0  initial release
// ============================================================================
package poly_eval_pkg;

   // Evaluator control states
   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_WAIT = 2'd1,
      S_CALC = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Width of the load index: it has to hold 0..deg (coefficients) plus deg+1 (x)
   function automatic int idx_w(input int deg);
      return $clog2(deg + 2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/poly_mac.sv
`default_nettype none
// ============================================================================
//  Module   : poly_mac
//  Purpose  : Combinational multiply-accumulate acc*x + c for one Horner step.
//             Build option POLY_SAT_EN: clamp to 2^W-1 and flag saturation;
//             otherwise the result wraps modulo 2^W and o_sat stays 0.
//  Revision : 1.0  initial release
// ============================================================================
module poly_mac #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_acc,
   input  logic [W-1:0] i_x,
   input  logic [W-1:0] i_c,
   output logic [W-1:0] o_sum,
   output logic         o_sat
);

`ifdef POLY_SAT_EN
   logic [2*W-1:0] w_prod;
   logic [2*W:0]   w_sum;

   // Full-width product and sum; any bit above W means the step overflowed
   always_comb begin
      w_prod = {{W{1'b0}}, i_acc} * {{W{1'b0}}, i_x};
      w_sum  = {1'b0, w_prod} + {{(W + 1){1'b0}}, i_c};
      o_sum  = w_sum[W-1:0];
      o_sat  = 1'b0;
      if (w_sum[2*W:W] != '0) begin
         o_sum = {W{1'b1}};
         o_sat = 1'b1;
      end
   end
`else
   logic [W-1:0] w_prod;

   // Only the low W bits survive truncation, so compute just those
   always_comb begin
      w_prod = i_acc * i_x;
      o_sum  = w_prod + i_c;
      o_sat  = 1'b0;
   end
`endif

endmodule
`default_nettype wire

// File: rtl/poly_eval_horner.sv
`default_nettype none
// ============================================================================
//  Module   : poly_eval_horner
//  Purpose  : Polynomial evaluator y = c[N]x^N + ... + c[0] using Horner's
//             rule, one MAC per cycle. Words are loaded highest coefficient
//             first, then x, one per Go press/release.
//             Build option POLY_SAT_EN: saturating MACs with sticky overflow.
//  Revision : 1.0  initial release
// ============================================================================
module poly_eval_horner
   import poly_eval_pkg::*;
#(
   parameter int W      = 8,
   parameter int DEGREE = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_go,
   input  logic [W-1:0]               i_data_in,
   output logic [idx_w(DEGREE)-1:0]   o_load_idx,
   output logic                       o_busy,
   output logic [W-1:0]               o_data_result,
   output logic                       o_result_valid,
   output logic                       o_overflow
);

   localparam int                IDX_W       = idx_w(DEGREE);
   localparam logic [IDX_W-1:0]  c_IDX_X     = IDX_W'(DEGREE + 1);
   localparam logic [IDX_W-1:0]  c_STEP_LAST = IDX_W'(DEGREE - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [IDX_W-1:0] r_load_idx;
   logic [IDX_W-1:0] r_step;
   logic [W-1:0]     r_coef [0:DEGREE];
   logic [W-1:0]     r_x;
   logic [W-1:0]     r_acc;
   logic [W-1:0]     r_result;
   logic             r_valid;
   logic             r_ovf;

   logic             w_capture;
   logic [W-1:0]     w_mac_acc;
   logic [W-1:0]     w_mac_c;
   logic [W-1:0]     w_mac_sum;
   logic             w_mac_sat;

   // A press in S_DONE starts a fresh load exactly like S_LOAD (index is already 0)
   assign w_capture = ((r_state == S_LOAD) || (r_state == S_DONE)) && i_go;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_LOAD;
      else          r_state <= w_next_state;
   end

   // Next-state logic: handshake on Go, fixed N-cycle evaluation
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_LOAD:  if (i_go) w_next_state = S_WAIT;
         S_WAIT:  if (!i_go) w_next_state = (r_load_idx == c_IDX_X) ? S_CALC : S_LOAD;
         S_CALC:  if (r_step == c_STEP_LAST) w_next_state = S_DONE;
         S_DONE:  if (i_go) w_next_state = S_WAIT;
         default: w_next_state = S_LOAD;
      endcase
   end

   // Outputs: busy decodes the state, the rest come straight from registers
   always_comb begin
      o_busy         = (r_state == S_CALC);
      o_load_idx     = r_load_idx;
      o_data_result  = r_result;
      o_result_valid = r_valid;
      o_overflow     = r_ovf;
   end

   // Horner operands: the first step seeds the accumulator with c[N]
   always_comb begin
      w_mac_acc = (r_step == '0) ? r_coef[DEGREE] : r_acc;
      w_mac_c   = r_coef[0];
      for (int k = 0; k < DEGREE; k++) begin
         if (r_step == IDX_W'(k)) w_mac_c = r_coef[DEGREE - 1 - k];
      end
   end

   poly_mac #(.W(W)) u_mac (
      .i_acc (w_mac_acc),
      .i_x   (r_x),
      .i_c   (w_mac_c),
      .o_sum (w_mac_sum),
      .o_sat (w_mac_sat)
   );

   // Coefficient capture: load index i lands in c[N-i]; evaluation never writes here
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k <= DEGREE; k++) r_coef[k] <= '0;
      end else begin
         for (int k = 0; k <= DEGREE; k++) begin
            if (w_capture && (r_load_idx == IDX_W'(k))) r_coef[DEGREE - k] <= i_data_in;
         end
      end
   end

   // Datapath and counters: x capture, index/step sequencing, MAC, result
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_load_idx <= '0;
         r_step     <= '0;
         r_x        <= '0;
         r_acc      <= '0;
         r_result   <= '0;
         r_valid    <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_capture) begin
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            if (r_load_idx == c_IDX_X) r_x <= i_data_in;
         end
         if ((r_state == S_WAIT) && !i_go) begin
            if (r_load_idx == c_IDX_X) r_step     <= '0;
            else                       r_load_idx <= r_load_idx + IDX_W'(1);
         end
         if (r_state == S_CALC) begin
            r_acc <= w_mac_sum;
            if (w_mac_sat) r_ovf <= 1'b1;
            if (r_step == c_STEP_LAST) begin
               r_result   <= w_mac_sum;
               r_valid    <= 1'b1;
               r_load_idx <= '0;
            end else begin
               r_step <= r_step + IDX_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_poly_eval_horner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly_eval_horner
//  Purpose  : Directed self-checking bench for poly_eval_horner (N=2 and N=3).
//             Expected values follow the POLY_SAT_EN build option.
//  Revision : 1.0  initial release
// ============================================================================
module tb_poly_eval_horner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       go2, go3;
   logic [7:0] d2, d3;

   logic [1:0] idx2;
   logic       busy2, val2, ovf2;
   logic [7:0] res2;
   logic [2:0] idx3;
   logic       busy3, val3, ovf3;
   logic [7:0] res3;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0] c2, c1, c0, x;
      logic [7:0] exp_wrap;
      logic [7:0] exp_sat;
      bit         sat_ovf;
   } vec_t;

   vec_t vecs [7];

   always #5 clk = ~clk;

   poly_eval_horner #(.W(8), .DEGREE(2)) u_dut2 (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_go           (go2),
      .i_data_in      (d2),
      .o_load_idx     (idx2),
      .o_busy         (busy2),
      .o_data_result  (res2),
      .o_result_valid (val2),
      .o_overflow     (ovf2)
   );

   poly_eval_horner #(.W(8), .DEGREE(3)) u_dut3 (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_go           (go3),
      .i_data_in      (d3),
      .o_load_idx     (idx3),
      .o_busy         (busy3),
      .o_data_result  (res3),
      .o_result_valid (val3),
      .o_overflow     (ovf3)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One press/release of Go with a data word (sel=1 drives the N=3 instance)
   task automatic press(input bit sel, input logic [7:0] d);
      @(negedge clk);
      if (sel) begin d3 = d; go3 = 1'b1; end
      else     begin d2 = d; go2 = 1'b1; end
      @(negedge clk);
      go2 = 1'b0;
      go3 = 1'b0;
   endtask

   // From just before the release edge of x: expect 2 CALC cycles, then the result
   task automatic finish2(input string tag, input int exp_res, input int exp_ovf);
      @(posedge clk); #1;
      chk({tag, " busy"}, busy2, 1);
      chk({tag, " valid_early0"}, val2, 0);
      @(posedge clk); #1;
      chk({tag, " valid_early1"}, val2, 0);
      @(posedge clk); #1;
      chk({tag, " valid"}, val2, 1);
      chk({tag, " result"}, res2, exp_res);
      chk({tag, " overflow"}, ovf2, exp_ovf);
      chk({tag, " idx"}, idx2, 0);
      chk({tag, " busy_done"}, busy2, 0);
   endtask

   initial begin
      int exp_r, exp_o;

      vecs[0] = '{8'd2,   8'd3,   8'd4,   8'd5,  8'd69,  8'd69,  1'b0};
      vecs[1] = '{8'd1,   8'd0,   8'd0,   8'd20, 8'd144, 8'd255, 1'b1};
      vecs[2] = '{8'd1,   8'd1,   8'd1,   8'd2,  8'd7,   8'd7,   1'b0};
      vecs[3] = '{8'd0,   8'd0,   8'd0,   8'd0,  8'd0,   8'd0,   1'b0};
      vecs[4] = '{8'd255, 8'd255, 8'd255, 8'd1,  8'd253, 8'd255, 1'b1};
      vecs[5] = '{8'd3,   8'd0,   8'd7,   8'd10, 8'd51,  8'd255, 1'b1};
      vecs[6] = '{8'd0,   8'd5,   8'd9,   8'd7,  8'd44,  8'd44,  1'b0};

      rst_n = 1'b0;
      go2 = 1'b0; go3 = 1'b0;
      d2 = '0; d3 = '0;

      // Reset state
      #12;
      chk("rst idx2", idx2, 0);
      chk("rst busy2", busy2, 0);
      chk("rst res2", res2, 0);
      chk("rst val2", val2, 0);
      chk("rst ovf2", ovf2, 0);
      chk("rst idx3", idx3, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven evaluations, N=2
      for (int i = 0; i < 7; i++) begin
`ifdef POLY_SAT_EN
         exp_r = int'(vecs[i].exp_sat);
         exp_o = int'(vecs[i].sat_ovf);
`else
         exp_r = int'(vecs[i].exp_wrap);
         exp_o = 0;
`endif
         press(1'b0, vecs[i].c2);
         press(1'b0, vecs[i].c1);
         press(1'b0, vecs[i].c0);
         press(1'b0, vecs[i].x);
         finish2($sformatf("vec%0d", i), exp_r, exp_o);
      end

      // Go pulsed during evaluation: ignored, no capture, index stays at x slot
      press(1'b0, 8'd2);
      press(1'b0, 8'd3);
      press(1'b0, 8'd4);
      press(1'b0, 8'd5);
      @(posedge clk); #1;
      chk("calcgo busy0", busy2, 1);
      @(negedge clk);
      d2 = 8'hAA; go2 = 1'b1;
      @(posedge clk); #1;
      chk("calcgo busy1", busy2, 1);
      chk("calcgo idx", idx2, 3);
      @(negedge clk);
      go2 = 1'b0;
      @(posedge clk); #1;
      chk("calcgo valid", val2, 1);
      chk("calcgo result", res2, 69);
      chk("calcgo idx_done", idx2, 0);

      // New load from S_DONE: first press drops ResultValid
      @(negedge clk);
      d2 = 8'd1; go2 = 1'b1;
      @(posedge clk); #1;
      chk("reload valid_drop", val2, 0);
      chk("reload idx", idx2, 0);
      @(negedge clk);
      go2 = 1'b0;
      press(1'b0, 8'd1);
      press(1'b0, 8'd1);
      press(1'b0, 8'd2);
      finish2("reload", 7, 0);

      // Asynchronous reset after two words, then reload from c[N]
      press(1'b0, 8'd5);
      press(1'b0, 8'd6);
      @(posedge clk); #1;
      chk("midrst idx_before", idx2, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst idx", idx2, 0);
      chk("midrst res", res2, 0);
      chk("midrst val", val2, 0);
      chk("midrst busy", busy2, 0);
      chk("midrst ovf", ovf2, 0);
      @(negedge clk);
      rst_n = 1'b1;
      press(1'b0, 8'd2);
      press(1'b0, 8'd3);
      press(1'b0, 8'd4);
      press(1'b0, 8'd5);
      finish2("postrst", 69, 0);

      // N=3: x^3 + 1 at x=3, exactly three CALC cycles
      press(1'b1, 8'd1);
      press(1'b1, 8'd0);
      press(1'b1, 8'd0);
      press(1'b1, 8'd1);
      press(1'b1, 8'd3);
      @(posedge clk); #1;
      chk("n3 busy", busy3, 1);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk($sformatf("n3 valid_early%0d", k), val3, 0);
      end
      @(posedge clk); #1;
      chk("n3 valid", val3, 1);
      chk("n3 result", res3, 28);
      chk("n3 overflow", ovf3, 0);
      chk("n3 busy_done", busy3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
